// File: rtl/bldc_commutator_multi_pkg.sv
// Shared gate encodings, invalid hall codes and the six-step commutation table.
// Latency: none (constants and pure functions only).
// Backpressure: none.
package bldc_pkg;

  localparam logic [1:0] G_OFF = 2'b00;
  localparam logic [1:0] G_HI  = 2'b10;
  localparam logic [1:0] G_LO  = 2'b01;

  localparam logic [2:0] H_BAD0 = 3'b000;
  localparam logic [2:0] H_BAD1 = 3'b111;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] c;
  } phase_req_t;

  function automatic logic hall_valid(input logic [2:0] h);
    return (h != H_BAD0) && (h != H_BAD1);
  endfunction

  // Swapping hs/ls bits turns HI into LO and back; OFF is unchanged.
  function automatic logic [1:0] flip(input logic [1:0] g);
    return {g[0], g[1]};
  endfunction

  // Forward table drives the hi phase high and the lo phase low; reverse swaps them.
  function automatic phase_req_t six_step(input logic [2:0] h, input logic rev);
    phase_req_t r;
    case (h)
      3'b001:  r = '{a: G_HI,  b: G_LO,  c: G_OFF};
      3'b011:  r = '{a: G_HI,  b: G_OFF, c: G_LO };
      3'b010:  r = '{a: G_OFF, b: G_HI,  c: G_LO };
      3'b110:  r = '{a: G_LO,  b: G_HI,  c: G_OFF};
      3'b100:  r = '{a: G_LO,  b: G_OFF, c: G_HI };
      3'b101:  r = '{a: G_OFF, b: G_LO,  c: G_HI };
      default: r = '{a: G_OFF, b: G_OFF, c: G_OFF};
    endcase
    if (rev) begin
      r.a = flip(r.a);
      r.b = flip(r.b);
      r.c = flip(r.c);
    end
    return r;
  endfunction

endpackage

// File: rtl/bldc_commutator_multi_if.sv
// Bundles the per-channel control inputs and gate/status outputs of the commutator.
// Latency: none (wires only).
// Backpressure: none; all signals are level-sampled every cycle.
interface bldc_commutator_multi_if #(
  parameter int N_CH  = 2,
  parameter int PER_W = 20
);
  logic [N_CH-1:0]       en;
  logic [N_CH-1:0]       pwm;
  logic [N_CH-1:0]       dir;
  logic [N_CH-1:0]       brake;
  logic [N_CH-1:0]       fault_clr;
  logic [3*N_CH-1:0]     hall;
  logic [2*N_CH-1:0]     gate_a;
  logic [2*N_CH-1:0]     gate_b;
  logic [2*N_CH-1:0]     gate_c;
  logic [N_CH-1:0]       fault;
  logic [N_CH-1:0]       hall_ok;
  logic [PER_W*N_CH-1:0] hall_per;

  modport master (
    output en, pwm, dir, brake, fault_clr, hall,
    input  gate_a, gate_b, gate_c, fault, hall_ok, hall_per
  );

  modport slave (
    input  en, pwm, dir, brake, fault_clr, hall,
    output gate_a, gate_b, gate_c, fault, hall_ok, hall_per
  );
endinterface

// File: rtl/bldc_commutator_multi_comm_ch.sv
// One motor channel: hall sync+filter, sticky fault, six-step table, per-phase dead time.
// Latency: HALL_FILT+2 cycles hall edge to accepted code; 1 cycle request to gate, plus dead time.
// Backpressure: none. BLDC_HALL_PERIOD_EN builds the hall period counter, else hall_per is 0.
module bldc_comm_ch
  import bldc_pkg::*;
#(
  parameter int HALL_FILT = 4,
  parameter int DEAD_CYC  = 8,
  parameter int PER_W     = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm,
  input  logic             dir,
  input  logic             brake,
  input  logic             fault_clr,
  input  logic [2:0]       hall,
  output logic [1:0]       gate_a,
  output logic [1:0]       gate_b,
  output logic [1:0]       gate_c,
  output logic             fault,
  output logic             hall_ok,
  output logic [PER_W-1:0] hall_per
);

  localparam int FW = $clog2(HALL_FILT + 1);
  localparam int DW = $clog2(DEAD_CYC + 1);

  logic [2:0]    h_s1, h_s2, cand, code;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic          acc;
  phase_req_t    req;
  logic [1:0]    rq   [3];
  logic [1:0]    go   [3];
  logic [DW-1:0] offc [3];

  // Filter count including the current cycle; acceptance fires once per stable code.
  always_comb begin
    fcnt_nxt = fcnt;
    if (h_s2 != cand)                fcnt_nxt = FW'(1);
    else if (fcnt != FW'(HALL_FILT)) fcnt_nxt = fcnt + 1'b1;
    acc = (fcnt_nxt == FW'(HALL_FILT)) && ((h_s2 != cand) || (fcnt != FW'(HALL_FILT)));
  end

  // Synchroniser, filter, accepted code and sticky fault (a new invalid code beats fault_clr).
  always_ff @(posedge clk) begin
    if (rst) begin
      h_s1    <= '0;
      h_s2    <= '0;
      cand    <= '0;
      fcnt    <= '0;
      code    <= '0;
      hall_ok <= 1'b0;
      fault   <= 1'b0;
    end else begin
      h_s1 <= hall;
      h_s2 <= h_s1;
      cand <= h_s2;
      fcnt <= fcnt_nxt;
      if (acc) begin
        code    <= h_s2;
        hall_ok <= hall_valid(h_s2);
      end
      if (acc && !hall_valid(h_s2)) fault <= 1'b1;
      else if (fault_clr)           fault <= 1'b0;
    end
  end

  // Per-phase request in priority order: off conditions, brake, pwm gap, table.
  always_comb begin
    req = '{a: G_OFF, b: G_OFF, c: G_OFF};
    if (!en || fault || !hall_ok) req = '{a: G_OFF, b: G_OFF, c: G_OFF};
    else if (brake)               req = '{a: G_LO,  b: G_LO,  c: G_LO };
    else if (pwm)                 req = six_step(code, dir);
    rq[0] = req.a;
    rq[1] = req.b;
    rq[2] = req.c;
  end

  // Dead time: offc counts cycles the phase has been 00, including the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        go[i]   <= G_OFF;
        offc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (rq[i] == G_OFF) begin
          go[i] <= G_OFF;
          if (go[i] != G_OFF)                offc[i] <= DW'(1);
          else if (offc[i] != DW'(DEAD_CYC)) offc[i] <= offc[i] + 1'b1;
        end else if (go[i] != G_OFF) begin
          if (rq[i] != go[i]) begin
            go[i]   <= G_OFF;
            offc[i] <= DW'(1);
          end
        end else if (offc[i] >= DW'(DEAD_CYC)) begin
          go[i] <= rq[i];
        end else begin
          offc[i] <= offc[i] + 1'b1;
        end
      end
    end
  end

  assign gate_a = go[0];
  assign gate_b = go[1];
  assign gate_c = go[2];

`ifdef BLDC_HALL_PERIOD_EN
  logic [PER_W-1:0] per_cnt, per_q;
  logic             chg;

  assign chg = acc && hall_valid(h_s2) && (h_s2 != code);

  // Period between accepted valid code changes; all-ones means stalled or unknown.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt <= '1;
      per_q   <= '1;
    end else if (acc && !hall_valid(h_s2)) begin
      per_cnt <= '1;
      per_q   <= '1;
    end else if (chg) begin
      per_q   <= (&per_cnt) ? per_cnt : per_cnt + 1'b1;
      per_cnt <= '0;
    end else if (!(&per_cnt)) begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  assign hall_per = per_q;
`else
  assign hall_per = '0;
`endif

endmodule

// File: rtl/bldc_commutator_multi.sv
// Multi-channel six-step BLDC commutator: N_CH independent bldc_comm_ch instances on flat buses.
// Latency: HALL_FILT+2 cycles hall to code, 1 cycle request to gate plus dead time.
// Backpressure: none. Optional hall period counter under BLDC_HALL_PERIOD_EN.
module bldc_commutator_multi #(
  parameter int N_CH      = 2,
  parameter int HALL_FILT = 4,
  parameter int DEAD_CYC  = 8,
  parameter int PER_W     = 20
) (
  input logic                    clk,
  input logic                    rst,
  bldc_commutator_multi_if.slave io
);

  // One channel per motor; each owns its slice of every bus.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    bldc_comm_ch #(
      .HALL_FILT (HALL_FILT),
      .DEAD_CYC  (DEAD_CYC),
      .PER_W     (PER_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (io.en[g]),
      .pwm       (io.pwm[g]),
      .dir       (io.dir[g]),
      .brake     (io.brake[g]),
      .fault_clr (io.fault_clr[g]),
      .hall      (io.hall[3*g +: 3]),
      .gate_a    (io.gate_a[2*g +: 2]),
      .gate_b    (io.gate_b[2*g +: 2]),
      .gate_c    (io.gate_c[2*g +: 2]),
      .fault     (io.fault[g]),
      .hall_ok   (io.hall_ok[g]),
      .hall_per  (io.hall_per[PER_W*g +: PER_W])
    );
  end

endmodule

// File: tb/tb_bldc_commutator_multi.sv
// Directed bench: vector table for steady-state commutation plus timing sequences.
// Channel 1 is held on a fixed hall code to confirm channel independence.
module tb_bldc_commutator_multi;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bldc_commutator_multi_if #(.N_CH(2), .PER_W(20)) io();

  bldc_commutator_multi #(
    .N_CH(2), .HALL_FILT(4), .DEAD_CYC(8), .PER_W(20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  typedef struct {
    logic [2:0] hall;
    logic       en, pwm, dir, brake;
    logic [7:0] exp;   // {gate_a, gate_b, gate_c, fault, hall_ok}
  } vec_t;

  vec_t vt [12];
  int   n_pass = 0, n_tot = 0;
  int   bad, aoff, took;

  logic [7:0] s0, s1;
  assign s0 = {io.gate_a[1:0], io.gate_b[1:0], io.gate_c[1:0], io.fault[0], io.hall_ok[0]};
  assign s1 = {io.gate_a[3:2], io.gate_b[3:2], io.gate_c[3:2], io.fault[1], io.hall_ok[1]};

  // Channel 1: hall 101 forward -> C high, B low, A off.
  localparam logic [7:0] CH1_EXP = 8'b00_01_10_0_1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic has11(input logic [7:0] s);
    return (s[7:6] == 2'b11) || (s[5:4] == 2'b11) || (s[3:2] == 2'b11);
  endfunction

  initial begin
    vt[0]  = '{3'b001, 1, 1, 0, 0, 8'b10_01_00_0_1};
    vt[1]  = '{3'b011, 1, 1, 0, 0, 8'b10_00_01_0_1};
    vt[2]  = '{3'b010, 1, 1, 0, 0, 8'b00_10_01_0_1};
    vt[3]  = '{3'b110, 1, 1, 0, 0, 8'b01_10_00_0_1};
    vt[4]  = '{3'b100, 1, 1, 0, 0, 8'b01_00_10_0_1};
    vt[5]  = '{3'b101, 1, 1, 0, 0, 8'b00_01_10_0_1};
    vt[6]  = '{3'b101, 1, 1, 1, 0, 8'b00_10_01_0_1};
    vt[7]  = '{3'b001, 1, 1, 1, 0, 8'b01_10_00_0_1};
    vt[8]  = '{3'b001, 1, 0, 1, 0, 8'b00_00_00_0_1};
    vt[9]  = '{3'b001, 1, 0, 1, 1, 8'b01_01_01_0_1};
    vt[10] = '{3'b001, 0, 1, 1, 0, 8'b00_00_00_0_1};
    vt[11] = '{3'b001, 1, 1, 0, 0, 8'b10_01_00_0_1};

    rst = 1'b1;
    io.en = 2'b11; io.pwm = 2'b11; io.dir = 2'b00; io.brake = 2'b00; io.fault_clr = 2'b00;
    io.hall = {3'b101, 3'b001};
    tick(3);
    chk("reset_ch0", 32'(s0), 32'h0);
    chk("reset_ch1", 32'(s1), 32'h0);
`ifdef BLDC_HALL_PERIOD_EN
    chk("reset_per", 32'(io.hall_per[19:0]), 32'hFFFFF);
`else
    chk("per_zero", 32'(io.hall_per[19:0]), 32'h0);
`endif
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (s0[7:2] != 6'b0 || s1[7:2] != 6'b0) bad++;
    end
    chk("post_reset_deadtime", 32'(bad), 32'd0);
    tick(20);

    // Steady-state table.
    for (int i = 0; i < 12; i++) begin
      io.hall[2:0] = vt[i].hall;
      io.en[0] = vt[i].en; io.pwm[0] = vt[i].pwm; io.dir[0] = vt[i].dir; io.brake[0] = vt[i].brake;
      tick(24);
      chk($sformatf("vec%0d_ch0", i), 32'(s0), 32'(vt[i].exp));
      chk($sformatf("vec%0d_ch1", i), 32'(s1), 32'(CH1_EXP));
    end

    // Rotation 001->011: gates change exactly one cycle after acceptance (HALL_FILT+2 = 6 edges).
    io.hall[2:0] = 3'b011;
    tick(6);
    chk("rot_before_accept", 32'(s0), 32'(8'b10_01_00_0_1));
    tick(1);
    chk("rot_after_accept", 32'(s0), 32'(8'b10_00_01_0_1));
    bad = 0;
    for (int i = 0; i < 13; i++) begin
      tick(1);
      if (s0[7:6] != 2'b10 || has11(s0)) bad++;
    end
    chk("rot_a_held_hi", 32'(bad), 32'd0);

    // Reversal on hall 001: A and B each spend exactly 8 cycles at 00.
    io.hall[2:0] = 3'b001;
    tick(24);
    io.dir[0] = 1'b1;
    aoff = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (s0[7:6] == 2'b00) aoff++;
      if (s0[7:6] == 2'b01) break;
    end
    chk("rev_a_off_cycles", 32'(aoff), 32'd8);
    chk("rev_final", 32'(s0), 32'(8'b01_10_00_0_1));

    // Glitch: 3-cycle pulse to 011 must be filtered out.
    io.dir[0] = 1'b0;
    tick(24);
    io.hall[2:0] = 3'b011;
    bad = 0;
    for (int i = 0; i < 23; i++) begin
      if (i == 3) io.hall[2:0] = 3'b001;
      tick(1);
      if (s0 != 8'b10_01_00_0_1) bad++;
    end
    chk("glitch_filtered", 32'(bad), 32'd0);

    // Invalid 111: sticky fault, gates off, persists after a valid code returns.
    io.hall[2:0] = 3'b111;
    tick(8);
    chk("fault_111", 32'(s0), 32'(8'b00_00_00_1_0));
    io.hall[2:0] = 3'b010;
    tick(20);
    chk("fault_sticky", 32'(s0), 32'(8'b00_00_00_1_1));
    io.fault_clr[0] = 1'b1;
    tick(1);
    io.fault_clr[0] = 1'b0;
    tick(24);
    chk("fault_cleared", 32'(s0), 32'(8'b00_10_01_0_1));
    chk("fault_ch1", 32'(s1), 32'(CH1_EXP));

    // fault_clr on the same edge as a new invalid acceptance: fault wins.
    io.hall[2:0] = 3'b000;
    tick(5);
    io.fault_clr[0] = 1'b1;
    tick(1);
    io.fault_clr[0] = 1'b0;
    chk("fault_vs_clr", 32'(s0[1]), 32'd1);
    tick(3);
    chk("fault_000_state", 32'(s0), 32'(8'b00_00_00_1_0));
    io.hall[2:0] = 3'b001;
    tick(8);
    io.fault_clr[0] = 1'b1;
    tick(1);
    io.fault_clr[0] = 1'b0;
    tick(24);
    chk("fault_recover", 32'(s0), 32'(8'b10_01_00_0_1));

    // pwm gap turns gates off immediately; brake from driving respects dead time.
    io.pwm[0] = 1'b0;
    tick(1);
    chk("pwm_off_1cyc", 32'(s0[7:2]), 32'h0);
    io.pwm[0] = 1'b1;
    tick(24);
    chk("pwm_resume", 32'(s0), 32'(8'b10_01_00_0_1));
    io.brake[0] = 1'b1;
    bad = 0; aoff = 0; took = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (has11(s0)) bad++;
      if (s0[7:6] == 2'b00) aoff++;
      if (s0[7:2] == 6'b01_01_01) begin
        took = i;
        break;
      end
    end
    chk("brake_never11", 32'(bad), 32'd0);
    chk("brake_all_lo", 32'(s0[7:2]), 32'(6'b01_01_01));
    chk("brake_a_off", 32'(aoff), 32'd8);
    chk("brake_within", 32'(took <= 9 && took > 0), 32'd1);
    chk("brake_ch1", 32'(s1), 32'(CH1_EXP));
    io.brake[0] = 1'b0;
    tick(24);

    // Reset mid-operation: gates off on next edge, dead time again after release.
    chk("pre_rst_drive", 32'(s0), 32'(8'b10_01_00_0_1));
    rst = 1'b1;
    tick(1);
    chk("rst_mid_ch0", 32'(s0[7:2]), 32'h0);
    chk("rst_mid_ch1", 32'(s1[7:2]), 32'h0);
    tick(2);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (s0[7:2] != 6'b0 || s1[7:2] != 6'b0) bad++;
    end
    chk("rst_release_deadtime", 32'(bad), 32'd0);
    tick(24);
    chk("rst_recover_ch0", 32'(s0), 32'(8'b10_01_00_0_1));
    chk("rst_recover_ch1", 32'(s1), 32'(CH1_EXP));

`ifdef BLDC_HALL_PERIOD_EN
    io.hall[2:0] = 3'b011;
    tick(1000);
    io.hall[2:0] = 3'b010;
    tick(20);
    chk("per_1000", 32'(io.hall_per[19:0]), 32'd1000);
    chk("per_ch1_stalled", 32'(io.hall_per[39:20]), 32'hFFFFF);
`else
    chk("per_zero_end", 32'(io.hall_per), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
